// File: rtl/answer_table.sv
// Answer table: slot 0 mirrors the frame counter, slots 1..DEPTH-1 are
// a writable table; supports single-word reads and full-table bursts.
module answer_table #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 20,
   parameter int ADDR_W = 5,
   parameter int STEP   = 10,
   parameter int CNT_W  = 8
) (
   input  logic              clk80MHz,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              scan_start,
   output logic [DATA_W-1:0] data,
   output logic              data_valid,
   output logic              data_last,
   output logic              busy,
   output logic              addr_err,
   output logic [CNT_W-1:0]  frame_cnt
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_idx;
   logic [DATA_W-1:0]   r_mem [1:DEPTH-1];

   logic                w_scan;
   logic                w_issue;
   logic [ADDR_W-1:0]   w_sel;
   logic                w_in_rng;
   logic                w_wr_rng;
   logic                w_hit_last;
   logic [DATA_W-1:0]   w_cnt_d;
   logic [CNT_W-1:0]    w_wr_cnt;
   logic [DATA_W-1:0]   w_word;

   // Width adaptation between counter and data words in both directions
   always_comb begin
      w_cnt_d  = '0;
      w_wr_cnt = '0;
      for (int b = 0; b < DATA_W && b < CNT_W; b++) begin
         w_cnt_d[b]  = frame_cnt[b];
         w_wr_cnt[b] = wr_data[b];
      end
   end

   assign w_scan   = (r_state == SCAN);
   assign w_issue  = w_scan ? !data_last : (scan_start | rd_en);
   assign w_sel    = w_scan ? r_idx
                   : (scan_start ? '0 : addr);
   assign w_in_rng = ({1'b0, w_sel} < LP_DEPTH);
   assign w_wr_rng = ({1'b0, wr_addr} < LP_DEPTH);
   assign w_hit_last = w_issue && (w_sel == LP_LAST);

   always_comb begin
      w_word = '0;
      if (w_sel == '0)
         w_word = w_cnt_d;
      else if (w_in_rng)
         w_word = r_mem[w_sel];
   end

   always_ff @(posedge clk80MHz or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         data_last  <= 1'b0;
         busy       <= 1'b0;
         addr_err   <= 1'b0;
         frame_cnt  <= '0;
         for (int i = 1; i < DEPTH; i++)
            r_mem[i] <= DATA_W'(i * STEP);
      end else begin
         data_valid <= w_issue;
         data_last  <= 1'b0;
         addr_err   <= 1'b0;
         if (w_issue)
            data <= w_word;
         case (r_state)
            IDLE: begin
               if (scan_start) begin
                  r_state <= SCAN;
                  busy    <= 1'b1;
                  r_idx   <= ADDR_W'(1);
               end else if (rd_en) begin
                  addr_err <= !w_in_rng;
               end
            end
            SCAN: begin
               // busy holds through the data_last cycle
               if (data_last) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  data_last <= (r_idx == LP_LAST);
                  r_idx     <= r_idx + ADDR_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_hit_last)
            frame_cnt <= frame_cnt + CNT_W'(1);
         // A counter write overrides the same-edge increment
         if (wr_en) begin
            if (wr_addr == '0)
               frame_cnt <= w_wr_cnt;
            else if (w_wr_rng)
               r_mem[wr_addr] <= wr_data;
         end
      end
   end

endmodule

// File: doc/answer_table.md
ANSWER_TABLE -- requirements
Module: answer_table

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning answer word width.
REQ-002 SHALL provide parameter DEPTH, default 20, meaning number of answer slots (DEPTH >= 2).
REQ-003 SHALL provide parameter ADDR_W, default 5, meaning address width (2**ADDR_W >= DEPTH).
REQ-004 SHALL provide parameter STEP, default 10, meaning reset-fill increment per slot.
REQ-005 SHALL provide parameter CNT_W, default 8, meaning frame counter width.
REQ-006 SHALL provide the ports below; clock is clk80MHz; reset is rst, asynchronous, active-low:
- clk80MHz  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- rd_en  in  1  single-word read request
- addr  in  ADDR_W  read address
- wr_en  in  1  table/counter write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- scan_start  in  1  start full-table burst
- data  out  DATA_W  registered answer word
- data_valid  out  1  data qualifier, one pulse per word
- data_last  out  1  high with final burst word
- busy  out  1  burst in progress
- addr_err  out  1  one-cycle pulse, out-of-range read
- frame_cnt  out  CNT_W  current frame counter

Function
REQ-007 Slot 0 SHALL read as frame_cnt zero-extended or truncated to DATA_W; slots 1..DEPTH-1 SHALL hold a writable table.
REQ-008 Single read: rd_en high in cycle N while idle -> data and data_valid=1 in cycle N+1; data_valid SHALL be 0 in every cycle without a word.
REQ-009 Read of addr >= DEPTH SHALL give data=0, data_valid=1, addr_err=1 for one cycle, no counter change.
REQ-010 Read of addr DEPTH-1 (single or burst) SHALL increment frame_cnt by 1 at that same edge, modulo 2**CNT_W (wrap to 0).
REQ-011 wr_en with wr_addr in 1..DEPTH-1 SHALL update that slot at the clock edge; wr_addr 0 SHALL load frame_cnt with wr_data (zero-extended/truncated to CNT_W); wr_addr >= DEPTH SHALL be ignored.
REQ-012 Read and write to the same slot in one cycle SHALL return the old value (read-before-write).
REQ-013 A counter write (wr_addr 0) coinciding with a DEPTH-1 read increment SHALL win; frame_cnt = written value.
REQ-014 FSM states IDLE and SCAN; IDLE->SCAN on scan_start; SCAN->IDLE after word DEPTH-1 is issued.
REQ-015 In SCAN, busy=1 and one word SHALL be output per cycle for slots 0..DEPTH-1 in order, first word one cycle after scan_start, data_last=1 only with slot DEPTH-1.
REQ-016 Burst slot 0 SHALL carry frame_cnt value before the burst's own increment.
REQ-017 rd_en and scan_start SHALL be ignored while busy=1; scan_start together with rd_en in IDLE SHALL start the burst and drop the read.
REQ-018 Writes SHALL be accepted in SCAN; a write to a slot not yet output SHALL appear in that burst.
REQ-019 busy SHALL deassert in the cycle after data_last, allowing a new request that cycle.

Reset
REQ-020 On rst low, immediately: data=0, data_valid=0, data_last=0, busy=0, addr_err=0, frame_cnt=0, FSM=IDLE.
REQ-021 On reset, slot i (1..DEPTH-1) SHALL be (i*STEP) mod 2**DATA_W.
REQ-022 Reset mid-burst SHALL abort it; no further words after rst release without a new request.

Verification
REQ-023 Defaults, reset, rd_en addr=3 -> next cycle data=30, data_valid=1; addr=0 -> data=0.
REQ-024 20 single reads of addr 19 -> frame_cnt=20; 256 reads from reset -> frame_cnt=0 (wrap).
REQ-025 scan_start -> 20 consecutive valid words 0,10,...,190 (slot0=frame_cnt), data_last on the 20th, busy falls next cycle, frame_cnt +1.
REQ-026 Write slot 5=0xAA with same-cycle read of 5 -> data=50; next read -> 0xAA; write wr_addr 0=7 with read of 19 -> frame_cnt=7.
REQ-027 Read addr=25 -> data=0, addr_err pulse, frame_cnt unchanged; rd_en during burst -> no extra words.
REQ-028 rst low at burst word 10 -> all outputs 0 asynchronously, no words after release, table restored to reset fill.
